// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
//   Shared definitions for the 32-bit bus memory slave:
//     - control bus bit positions (wait, we, burst code field)
//     - burst code constants and burst-code-to-length helper
//     - slave FSM state encodings
// ---------------------------------------------------------------------------
package bus_pkg;

    // Control bus bit positions
    localparam int CTRL_WAIT     = 0;
    localparam int CTRL_WE       = 1;
    localparam int CTRL_BURST_LO = 2;
    localparam int CTRL_BURST_HI = 4;

    // Burst codes; 1xx is reserved and decodes as a single beat
    localparam logic [2:0] BURST_1 = 3'b000;
    localparam logic [2:0] BURST_2 = 3'b001;
    localparam logic [2:0] BURST_4 = 3'b010;
    localparam logic [2:0] BURST_8 = 3'b011;

    // Slave FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_LAT   = 3'd2;
    localparam logic [2:0] ST_READY = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;

    // Number of beats (1..8) for a burst code
    function automatic logic [3:0] burst_len(input logic [2:0] code);
        logic [3:0] len;
        case (code)
            BURST_1: len = 4'd1;
            BURST_2: len = 4'd2;
            BURST_4: len = 4'd4;
            BURST_8: len = 4'd8;
            default: len = 4'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/bus_mem_slave_if.sv
// ---------------------------------------------------------------------------
// bus_mem_slave_if
//   Bus-side signals seen by the memory slave.
//     ack        grant from the arbiter to the current master
//     bus_in     address (address phase) / write data (data phase)
//     ctrl_in    master control: [4:2] burst code, [1] we
//     bus_out    read data from the slave, 0 when not driving
//     bus_drive  high while bus_out carries valid read data
//     ctrl_out   slave control: {7'b0, wait}
//   Modports: master (drives ack/bus_in/ctrl_in), slave (drives the outputs).
// ---------------------------------------------------------------------------
interface bus_mem_slave_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int CTRL_WIDTH = 8
);
    logic                  ack;
    logic [BUS_WIDTH-1:0]  bus_in;
    logic [CTRL_WIDTH-1:0] ctrl_in;
    logic [BUS_WIDTH-1:0]  bus_out;
    logic                  bus_drive;
    logic [CTRL_WIDTH-1:0] ctrl_out;

    modport master (
        output ack,
        output bus_in,
        output ctrl_in,
        input  bus_out,
        input  bus_drive,
        input  ctrl_out
    );

    modport slave (
        input  ack,
        input  bus_in,
        input  ctrl_in,
        output bus_out,
        output bus_drive,
        output ctrl_out
    );
endinterface

// File: rtl/bus_slave_ram.sv
// ---------------------------------------------------------------------------
// bus_slave_ram
//   DEPTH x WIDTH word array: synchronous write port, asynchronous read port.
//   Contents are not reset.
//     clk    clock (write on rising edge)
//     we     write enable
//     waddr  write address
//     wdata  write data
//     raddr  read address
//     rdata  read data (combinational)
// ---------------------------------------------------------------------------
module bus_slave_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_mem_slave.sv
// ---------------------------------------------------------------------------
// bus_mem_slave
//   Burst-capable memory slave on the shared 32-bit bus. Snoops the arbiter
//   grant, captures address/control in the address phase, holds wait for
//   WAIT_CYCLES cycles, then serves a 1/2/4/8-beat read or write burst from
//   an internal word array. Addresses wrap modulo DEPTH.
//     clk    bus clock (rising edge)
//     rst_n  asynchronous active-low reset
//     bus    slave modport of bus_mem_slave_if (ack, bus_in, ctrl_in in;
//            bus_out, bus_drive, ctrl_out out)
// ---------------------------------------------------------------------------
import bus_pkg::*;

module bus_mem_slave #(
    parameter int BUS_WIDTH   = 32,
    parameter int CTRL_WIDTH  = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_mem_slave_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LAT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    // Final latency count; irrelevant when WAIT_CYCLES == 0 since LAT is skipped
    localparam logic [LAT_W-1:0] LAT_LAST =
        LAT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [2:0]       state_q;
    logic             ack_q;
    logic [AW-1:0]    addr_q;
    logic             we_q;
    logic [2:0]       last_q;   // index of final beat (len - 1)
    logic [2:0]       beat_q;
    logic [LAT_W-1:0] lat_q;

    logic             wait_w;
    logic             data_phase;
    logic             rd_en;
    logic             ram_we;
    logic [AW-1:0]    beat_addr;
    logic [BUS_WIDTH-1:0] rdata;

    // ctrl_in[7:5] and the wait position of ctrl_in carry nothing for us
    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^{bus.ctrl_in[CTRL_WIDTH-1:CTRL_BURST_HI+1],
                                bus.ctrl_in[CTRL_WAIT]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            last_q  <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
        end else begin
            ack_q <= bus.ack;
            case (state_q)
                ST_IDLE: begin
                    // Only a fresh grant edge starts a transfer
                    if (bus.ack && !ack_q) begin
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    addr_q  <= bus.bus_in[AW-1:0];
                    we_q    <= bus.ctrl_in[CTRL_WE];
                    last_q  <= 3'(burst_len(bus.ctrl_in[CTRL_BURST_HI:CTRL_BURST_LO]) - 4'd1);
                    lat_q   <= '0;
                    state_q <= (WAIT_CYCLES > 0) ? ST_LAT : ST_READY;
                end
                ST_LAT: begin
                    if (lat_q == LAT_LAST) begin
                        state_q <= ST_READY;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                ST_READY: begin
                    beat_q  <= '0;
                    state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (beat_q == last_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        beat_q <= beat_q + 3'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from registered state only
    assign wait_w     = (state_q == ST_ADDR) || (state_q == ST_LAT);
    assign data_phase = (state_q == ST_DATA);
    assign rd_en      = data_phase && !we_q;
    assign ram_we     = data_phase && we_q;
    assign beat_addr  = addr_q + AW'(beat_q);

    bus_slave_ram #(
        .DEPTH (DEPTH),
        .WIDTH (BUS_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (beat_addr),
        .wdata (bus.bus_in),
        .raddr (beat_addr),
        .rdata (rdata)
    );

    assign bus.bus_out   = rd_en ? rdata : '0;
    assign bus.bus_drive = rd_en;

    always_comb begin
        bus.ctrl_out            = '0;
        bus.ctrl_out[CTRL_WAIT] = wait_w;
    end

endmodule

// File: tb/tb_bus_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_bus_mem_slave
//   Directed bench for bus_mem_slave. Two instances: WAIT_CYCLES=2 and
//   WAIT_CYCLES=0, selected by 'sel'; the unselected one sees ack low.
// ---------------------------------------------------------------------------
module tb_bus_mem_slave;

    logic        clk;
    logic        rst_n;
    logic        sel;        // 0: WAIT_CYCLES=2 instance, 1: WAIT_CYCLES=0
    logic        ack_d;
    logic [31:0] bus_in_d;
    logic [7:0]  ctrl_in_d;

    int errors;
    int checks;

    bus_mem_slave_if #(.BUS_WIDTH(32), .CTRL_WIDTH(8)) bus2 ();
    bus_mem_slave_if #(.BUS_WIDTH(32), .CTRL_WIDTH(8)) bus0 ();

    assign bus2.ack     = (sel == 1'b0) ? ack_d : 1'b0;
    assign bus2.bus_in  = bus_in_d;
    assign bus2.ctrl_in = ctrl_in_d;
    assign bus0.ack     = (sel == 1'b1) ? ack_d : 1'b0;
    assign bus0.bus_in  = bus_in_d;
    assign bus0.ctrl_in = ctrl_in_d;

    bus_mem_slave #(
        .BUS_WIDTH   (32),
        .CTRL_WIDTH  (8),
        .DEPTH       (64),
        .WAIT_CYCLES (2)
    ) u_w2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    bus_mem_slave #(
        .BUS_WIDTH   (32),
        .CTRL_WIDTH  (8),
        .DEPTH       (64),
        .WAIT_CYCLES (0)
    ) u_w0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    logic [7:0]  obs_ctrl;
    logic        obs_drive;
    logic [31:0] obs_out;
    assign obs_ctrl  = sel ? bus0.ctrl_out  : bus2.ctrl_out;
    assign obs_drive = sel ? bus0.bus_drive : bus2.bus_drive;
    assign obs_out   = sel ? bus0.bus_out   : bus2.bus_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transfer, starting with ack rising in the current cycle.
    // wc = latency of the selected instance; data = write data / expected read data.
    task automatic xfer(input int wc, input logic [31:0] addr, input logic [2:0] code,
                        input bit wr, input logic [31:0] data [8], input bit keep_ack,
                        input string tag);
        int n;
        case (code)
            3'b000:  n = 1;
            3'b001:  n = 2;
            3'b010:  n = 4;
            3'b011:  n = 8;
            default: n = 1;
        endcase
        ack_d = 1'b1;
        chk({tag, " T ctrl"}, 32'(obs_ctrl), 32'h0);
        tick();
        // ADDR: ignored control bits set to make sure they stay ignored
        chk({tag, " addr ctrl"}, 32'(obs_ctrl), 32'h1);
        chk({tag, " addr drive"}, 32'(obs_drive), 32'h0);
        bus_in_d  = addr;
        ctrl_in_d = {3'b111, code, wr, 1'b1};
        tick();
        bus_in_d  = 32'hDEAD_BEEF;
        ctrl_in_d = 8'h00;
        for (int i = 0; i < wc; i++) begin
            chk({tag, " lat ctrl"}, 32'(obs_ctrl), 32'h1);
            chk({tag, " lat drive"}, 32'(obs_drive), 32'h0);
            tick();
        end
        chk({tag, " ready ctrl"}, 32'(obs_ctrl), 32'h0);
        chk({tag, " ready drive"}, 32'(obs_drive), 32'h0);
        tick();
        for (int i = 0; i < n; i++) begin
            if (wr) bus_in_d = data[i];
            chk({tag, " beat ctrl"}, 32'(obs_ctrl), 32'h0);
            chk({tag, " beat drive"}, 32'(obs_drive), wr ? 32'h0 : 32'h1);
            chk({tag, " beat data"}, obs_out, wr ? 32'h0 : data[i]);
            tick();
        end
        bus_in_d = 32'h0;
        chk({tag, " end ctrl"}, 32'(obs_ctrl), 32'h0);
        chk({tag, " end drive"}, 32'(obs_drive), 32'h0);
        chk({tag, " end data"}, obs_out, 32'h0);
        if (!keep_ack) begin
            ack_d = 1'b0;
            tick();
        end
    endtask

    logic [31:0] d [8];
    logic [31:0] d16 [8];

    initial begin
        errors    = 0;
        checks    = 0;
        sel       = 1'b0;
        ack_d     = 1'b0;
        bus_in_d  = 32'h0;
        ctrl_in_d = 8'h0;
        rst_n     = 1'b0;
        tick();
        tick();
        chk("reset w2 ctrl", 32'(bus2.ctrl_out), 32'h0);
        chk("reset w2 drive", 32'(bus2.bus_drive), 32'h0);
        chk("reset w2 out", bus2.bus_out, 32'h0);
        chk("reset w0 ctrl", 32'(bus0.ctrl_out), 32'h0);
        chk("reset w0 drive", 32'(bus0.bus_drive), 32'h0);
        rst_n = 1'b1;
        tick();

        // Write burst 4 at 8 with 0..3, then read it back
        for (int i = 0; i < 8; i++) d[i] = 32'(i);
        xfer(2, 32'd8, 3'b010, 1'b1, d, 1'b0, "wr8");
        xfer(2, 32'd8, 3'b010, 1'b0, d, 1'b0, "rd8");

        // Reset during LAT
        ack_d = 1'b1;
        tick();
        bus_in_d  = 32'd8;
        ctrl_in_d = 8'b0000_1000;
        tick();
        chk("pre-reset lat ctrl", 32'(obs_ctrl), 32'h1);
        ack_d     = 1'b0;
        ctrl_in_d = 8'h0;
        rst_n     = 1'b0;
        #1;
        chk("rst lat ctrl", 32'(obs_ctrl), 32'h0);
        chk("rst lat drive", 32'(obs_drive), 32'h0);
        chk("rst lat out", obs_out, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        xfer(2, 32'd8, 3'b010, 1'b0, d, 1'b0, "post-rst rd8");

        // Wrap at top of array
        d[0] = 32'hA0A0_0001; d[1] = 32'hB0B0_0002;
        d[2] = 32'hC0C0_0003; d[3] = 32'hD0D0_0004;
        xfer(2, 32'd62, 3'b010, 1'b1, d, 1'b0, "wr wrap");
        xfer(2, 32'd62, 3'b010, 1'b0, d, 1'b0, "rd wrap");
        d[0] = 32'hC0C0_0003; d[1] = 32'hD0D0_0004;
        xfer(2, 32'd0, 3'b001, 1'b0, d, 1'b0, "rd wrap low");

        // Burst codes: 011 writes 8, 000 and reserved 101 read one beat
        for (int i = 0; i < 8; i++) d16[i] = 32'h100 + 32'(i) * 32'h11;
        xfer(2, 32'd16, 3'b011, 1'b1, d16, 1'b0, "wr b8");
        d[0] = d16[0];
        xfer(2, 32'd16, 3'b000, 1'b0, d, 1'b0, "rd b1");
        d[0] = d16[1];
        xfer(2, 32'd17, 3'b101, 1'b0, d, 1'b0, "rd rsv");
        xfer(2, 32'd16, 3'b011, 1'b0, d16, 1'b0, "rd b8");

        // Held grant must not retrigger; a dropped and re-raised grant must
        d[0] = 32'd0; d[1] = 32'd1;
        xfer(2, 32'd8, 3'b001, 1'b0, d, 1'b1, "rd held");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held ack ctrl", 32'(obs_ctrl), 32'h0);
            chk("held ack drive", 32'(obs_drive), 32'h0);
        end
        ack_d = 1'b0;
        tick();
        d[0] = 32'd2;
        xfer(2, 32'd10, 3'b000, 1'b0, d, 1'b0, "rd regrant");

        // Zero-latency instance
        sel = 1'b1;
        tick();
        d[0] = 32'h5555_AAAA; d[1] = 32'h6666_9999;
        xfer(0, 32'd5, 3'b001, 1'b1, d, 1'b0, "w0 wr");
        xfer(0, 32'd5, 3'b001, 1'b0, d, 1'b0, "w0 rd");
        sel = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_mem_slave.md
# bus_mem_slave

Burst-capable memory slave for the shared 32-bit bus; it is the downstream consumer of the bus masters. It snoops the arbiter grant and captures address and control in the address phase. It then holds WAIT for a fixed latency and serves a read or write burst of 1, 2, 4 or 8 beats from an internal word array. Its WAIT bit and read data are OR'd or muxed onto the shared bus by the top level.

## Interface
- BUS_WIDTH, 32, data/address width
- CTRL_WIDTH, 8, control bus width
- DEPTH, 64, words of storage (power of two); address uses low log2(DEPTH) bits
- WAIT_CYCLES, 2, cycles WAIT is held high after the address phase (0 allowed)
- clk  in  1  bus clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ack  in  1  arbiter grant to the current master
- bus_in  in  BUS_WIDTH  shared bus: address in address phase, write data in data phase
- ctrl_in  in  CTRL_WIDTH  master control: [4:2] burst code, [1] we; [7:5] ignored
- bus_out  out  BUS_WIDTH  read data; 0 when not driving
- bus_drive  out  1  high while bus_out carries valid read data
- ctrl_out  out  CTRL_WIDTH  {7'b0, wait}; wait in bit 0

## Operation
- States: IDLE, ADDR, LAT, READY, DATA.
- IDLE: wait=0, bus_drive=0. Registered ack_q tracks ack; on ack && !ack_q (rising grant) -> ADDR. A grant held high from a previous transfer does not retrigger.
- ADDR, one cycle, master presents address:
  - capture addr <= bus_in[log2(DEPTH)-1:0], we <= ctrl_in[1], len from ctrl_in[4:2].
  - wait=1.
  - -> LAT if WAIT_CYCLES>0, else -> READY.
- Burst codes: 000=1, 001=2, 010=4, 011=8; 1xx is reserved and treated as 1 beat.
- LAT: wait=1, latency counter counts WAIT_CYCLES cycles, then -> READY.
- READY, one cycle: wait=0 (the master samples this and enters its data state next cycle). beat <= 0. -> DATA.
- DATA, len cycles, beat i = 0..len-1:
  - Read: bus_out = mem[(addr+i) mod DEPTH], bus_drive=1.
  - Write: mem[(addr+i) mod DEPTH] <= bus_in at the end of the beat, bus_out=0.
  - wait=0. After the last beat -> IDLE.
- Address arithmetic wraps modulo DEPTH; no error on wrap.
- A grant rising edge while not in IDLE is ignored. A rising edge on the cycle DATA returns to IDLE is also missed; the arbiter never regrants without first dropping ack.

## Timing
- Reset: async to IDLE; wait=0, bus_out=0, bus_drive=0, counters 0, ack_q=0. Memory contents are not reset.
- Cycle numbering, with T = the cycle ack first seen high:
  - T+1 ADDR.
  - T+2..T+1+W LAT (W=WAIT_CYCLES).
  - T+2+W READY.
  - Data beats T+3+W..T+2+W+len.
- Read data is combinational from the array and stable for the full beat cycle. The master captures it on the closing edge.
- Write data is sampled on the closing edge of each beat.
- Reset asserted mid-burst: immediate return to IDLE, outputs to reset values. A partially written burst keeps the beats already written.
- wait is registered-state decoded (Moore) and glitch-free.

## Structure
- bus_pkg holds:
  - ctrl bit positions: CTRL_WAIT=0, CTRL_WE=1, CTRL_BURST_LO=2, CTRL_BURST_HI=4
  - burst code constants and a burst-code-to-length function
  - state encodings
- One sub-module, bus_slave_ram: DEPTH x BUS_WIDTH array, synchronous write port (we, waddr, wdata), asynchronous read port (raddr, rdata). The slave FSM, latency counter and beat counter live in bus_mem_slave.

## Test plan
- Reset mid-LAT (WAIT_CYCLES=2): rst_n low one cycle -> wait=0, bus_drive=0 immediately; a subsequent ack rising edge starts a clean transfer.
- Write burst 4 at addr 8, data 0,1,2,3, WAIT_CYCLES=2:
  - wait high at T+1..T+3, low at T+4.
  - mem[8..11] = 0,1,2,3 after T+8.
  - bus_drive never high.
- Read burst 4 at addr 8 after that write -> bus_out = 0,1,2,3 on beats T+5..T+8, bus_drive high exactly those 4 cycles, 0 otherwise.
- Wrap: write burst 4 at addr DEPTH-2 with A,B,C,D -> mem[62]=A, mem[63]=B, mem[0]=C, mem[1]=D (DEPTH=64).
- Burst codes: code 000 -> 1 beat, 011 -> 8 beats, 101 -> 1 beat. WAIT_CYCLES=0 -> READY directly follows ADDR (wait high only at T+1).
- ack held high across two back-to-back transfers without dropping -> second transfer not started. ack dropped one cycle then raised -> second transfer served.
